sa_result_drain: RTL
====================

Name: sa_result_drain

Overview:
- Downstream of the systolic core's per-row result outputs.
- Waits until every row reports a buffered result, then snapshots all ROWS results in one cycle and acknowledges them back to the core with a single read pulse.
- Serialises the snapshot onto one ready/valid stream, one row per beat, for the wrapper or host interface.
- Frees the core's output buffers early, so the array can keep computing while the drain streams out.

Parameters:
- ROWS, 8, number of result rows; width of the parallel result interface.
- OUTWIDTH, 32, result word width in bits.
- CNTWIDTH, 16, width of the drained-tile counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous assert, active-low.
- res_in  input  OUTWIDTH x ROWS (unpacked [0:ROWS-1])  per-row result words from the core.
- res_valid  input  1 x ROWS (unpacked [0:ROWS-1])  per-row result-valid flags.
- res_read  output  1  one-cycle pulse telling the core all buffered results are consumed.
- out_data  output  OUTWIDTH  streamed result word.
- out_row  output  $clog2(ROWS)  row index of the current beat.
- out_last  output  1  high on the beat with out_row == ROWS-1.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- tile_count  output  CNTWIDTH  number of fully drained tiles.
- busy  output  1  high while in STREAM.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rstn low asynchronously clears all state and outputs: state=IDLE, res_read=0, out_valid=0, out_last=0, out_row=0, out_data=0, tile_count=0, busy=0.
  - Reset mid-stream discards the snapshot; there is no partial resume.
- States
  - IDLE:
    - Capture condition: all ROWS res_valid bits are 1 and res_read is currently 0.
    - On capture, at the clock edge: snapshot <= res_in for all rows, row pointer <= 0, state <= STREAM, res_read <= 1.
  - STREAM:
    - out_valid=1; out_data=snapshot[ptr]; out_row=ptr; out_last=(ptr==ROWS-1).
    - A beat transfers on a rising edge with out_valid && out_ready.
    - Non-last beat transferred: ptr increments.
    - Last beat transferred: tile_count increments, wrapping modulo 2^CNTWIDTH.
      - If the capture condition holds on that same edge: recapture, ptr <= 0, stay in STREAM, res_read <= 1. Back-to-back tiles have no bubble.
      - Otherwise: state <= IDLE.
- Timing
  - res_read is registered and high for exactly one cycle after each capture edge.
  - res_valid is ignored while res_read is high. The core needs one cycle to drop its valids, so this prevents a double capture.
  - Latency: the first beat's out_valid rises the cycle after the capture edge, coincident with the res_read pulse.
  - ROWS beats per tile at full throughput.
- Stream rules
  - While out_valid && !out_ready, out_data, out_row and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Snapshot and partial valids
  - The snapshot is only written on a capture edge.
  - res_in changes during STREAM do not affect out_data.
  - Partial valid (some but not all rows): no capture, no res_read; the drain waits indefinitely.
- busy is the registered equivalent of state==STREAM.

Optional Feature:
- Macro: SA_DRAIN_RELU_EN.
- When defined:
  - Each result is treated as a signed OUTWIDTH value at capture.
  - Negative words are replaced by 0 before being stored in the snapshot.
  - Non-negative words pass unchanged.
  - No added latency.
- When undefined: words pass through bit-exact.

Test Plan:
- Reset, then assert all res_valid with res_in[r]=r+100, out_ready=1 throughout:
  - res_read pulses once, on the cycle after capture;
  - 8 beats carry 100..107 with out_row 0..7;
  - out_last is high only on beat 7;
  - tile_count=1;
  - return to IDLE.
- Backpressure: out_ready toggles 1,0,0,1,...:
  - data, row and last hold stable during stalls;
  - no beat is dropped or duplicated.
- Sticky valids: hold res_valid high for 2 cycles after the capture edge:
  - exactly one capture and one res_read pulse;
  - no second tile is started.
- Back-to-back: second tile of res_in[r]=200+r is valid when the last beat of the first tile is accepted:
  - the second tile's first beat (200) follows immediately with no idle cycle;
  - res_read pulses again;
  - tile_count=2.
- Partial valid (rows 0..6 set, row 7 clear) for 20 cycles:
  - out_valid=0 and res_read=0 throughout;
  - setting row 7 triggers the capture.
- Reset mid-stream after beat 3: outputs clear immediately (asynchronously); tile_count=0.
- With SA_DRAIN_RELU_EN defined: res_in[2]=0xFFFFFFF6 (-10) streams as 0; res_in[3]=5 streams as 5.

Source files
------------

// File: rtl/sa_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_drain
// Description : Snapshots all systolic-array row results once every row is
//               valid, acknowledges them with one res_read pulse, then streams
//               the snapshot one row per beat on a ready/valid interface.
//               Optional macro SA_DRAIN_RELU_EN clamps negative words to zero
//               at capture.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int CNTWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [OUTWIDTH-1:0]       res_in    [0:ROWS-1],
    input  logic                      res_valid [0:ROWS-1],
    output logic                      res_read,
    output logic [OUTWIDTH-1:0]       out_data,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNTWIDTH-1:0]       tile_count,
    output logic                      busy
);

    localparam int                 c_PTRW     = $clog2(ROWS);
    localparam logic [c_PTRW-1:0]  c_LAST_ROW = c_PTRW'(ROWS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              r_state;
    logic [OUTWIDTH-1:0] r_snap [0:ROWS-1];
    logic [OUTWIDTH-1:0] w_cap  [0:ROWS-1];
    logic                w_all_valid;
    logic                w_capture;
    logic                w_xfer;
    logic                w_xfer_last;
    logic                w_load;
    logic [c_PTRW-1:0]   w_next_row;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
`ifdef SA_DRAIN_RELU_EN
            assign w_cap[r] = res_in[r][OUTWIDTH-1] ? '0 : res_in[r];
`else
            assign w_cap[r] = res_in[r];
`endif
        end
    endgenerate

    always_comb begin
        w_all_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            w_all_valid = w_all_valid & res_valid[r];
        end
    end

    // While res_read is high the core has not yet dropped its valids, so
    // they must not trigger a second capture of the same results.
    assign w_capture   = w_all_valid && !res_read;
    assign w_xfer      = out_valid && out_ready;
    assign w_xfer_last = w_xfer && out_last;
    assign w_load      = w_capture && ((r_state == S_IDLE) || w_xfer_last);
    assign w_next_row  = out_row + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            res_read   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_row    <= '0;
            out_data   <= '0;
            tile_count <= '0;
            busy       <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_snap[r] <= '0;
            end
        end else begin
            res_read <= 1'b0;
            if (w_xfer_last) begin
                tile_count <= tile_count + 1'b1;
            end

            // A new tile may load on the same edge the previous last beat
            // leaves, giving bubble-free back-to-back tiles.
            if (w_load) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_snap[r] <= w_cap[r];
                end
                r_state   <= S_STREAM;
                res_read  <= 1'b1;
                busy      <= 1'b1;
                out_valid <= 1'b1;
                out_row   <= '0;
                out_data  <= w_cap[0];
                out_last  <= (ROWS == 1);
            end else if (w_xfer_last) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (w_xfer) begin
                out_row  <= w_next_row;
                out_data <= r_snap[w_next_row];
                out_last <= (w_next_row == c_LAST_ROW);
            end
        end
    end

endmodule
`default_nettype wire
